// File: rtl/reg_write_scoreboard.sv
// rtl/reg_write_scoreboard.sv - pending-write scoreboard for scalar and vector register files
// Counts in-flight writes per register and stalls issue on RAW hazards or a saturated write count.
module reg_write_scoreboard #(
  parameter int NREG  = 16,
  parameter int REG_W = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rs1,
  input  logic             issue_rs1_vec,
  input  logic             issue_rs1_used,
  input  logic [REG_W-1:0] issue_rs2,
  input  logic             issue_rs2_vec,
  input  logic             issue_rs2_used,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_regWrite,
  input  logic             issue_regWriteV,
  input  logic             wb_regWrite,
  input  logic             wb_regWriteV,
  input  logic [REG_W-1:0] wb_rd,
  output logic             stall,
  output logic [NREG-1:0]  pending_s,
  output logic [NREG-1:0]  pending_v,
  output logic             busy,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_s     [NREG];
  logic [CNT_W-1:0] cnt_v     [NREG];
  logic [CNT_W-1:0] cnt_s_nxt [NREG];
  logic [CNT_W-1:0] cnt_v_nxt [NREG];
  logic [NREG-1:0]  pending_s_nxt;
  logic [NREG-1:0]  pending_v_nxt;
  logic             err_nxt;

  logic [CNT_W-1:0] rs1_cnt;
  logic [CNT_W-1:0] rs2_cnt;
  logic             haz_rs1;
  logic             haz_rs2;
  logic             dst_full;
  logic             accept;
  logic             issue_both;
  logic             wb_both;
  logic             inc_s;
  logic             inc_v;
  logic             dec_s;
  logic             dec_v;

  assign rs1_cnt = issue_rs1_vec ? cnt_v[issue_rs1] : cnt_s[issue_rs1];
  assign rs2_cnt = issue_rs2_vec ? cnt_v[issue_rs2] : cnt_s[issue_rs2];

  // Hazard decision looks only at registered counts; same-cycle WB is not forwarded.
  always_comb begin
    haz_rs1  = issue_rs1_used && (issue_rs1 != '0) && (rs1_cnt != '0);
    haz_rs2  = issue_rs2_used && (issue_rs2 != '0) && (rs2_cnt != '0);
    dst_full = (issue_rd != '0) &&
               ((issue_regWrite  && (cnt_s[issue_rd] == CNT_MAX)) ||
                (issue_regWriteV && (cnt_v[issue_rd] == CNT_MAX)));
    stall    = !rst && issue_valid && (haz_rs1 || haz_rs2 || dst_full);
  end

  assign accept     = issue_valid && !stall;
  assign issue_both = issue_regWrite && issue_regWriteV;
  assign wb_both    = wb_regWrite && wb_regWriteV;
  assign inc_s      = accept && issue_regWrite  && !issue_regWriteV && (issue_rd != '0);
  assign inc_v      = accept && issue_regWriteV && !issue_regWrite  && (issue_rd != '0);
  assign dec_s      = wb_regWrite  && !wb_regWriteV && (wb_rd != '0);
  assign dec_v      = wb_regWriteV && !wb_regWrite  && (wb_rd != '0);

  always_comb begin
    err_nxt = err;
    if (accept && issue_both && (issue_rd != '0)) err_nxt = 1'b1;
    if (wb_both && (wb_rd != '0)) err_nxt = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      cnt_s_nxt[i] = cnt_s[i];
      cnt_v_nxt[i] = cnt_v[i];
    end
    // Register 0 is never tracked, so the loop starts at 1.
    for (int i = 1; i < NREG; i++) begin
      logic is_inc_s, is_dec_s, is_inc_v, is_dec_v;
      is_inc_s = inc_s && (issue_rd == REG_W'(i));
      is_dec_s = dec_s && (wb_rd    == REG_W'(i));
      is_inc_v = inc_v && (issue_rd == REG_W'(i));
      is_dec_v = dec_v && (wb_rd    == REG_W'(i));
      if (is_dec_s && (cnt_s[i] == '0))  err_nxt = 1'b1;
      else if (is_inc_s && !is_dec_s)    cnt_s_nxt[i] = cnt_s[i] + CNT_ONE;
      else if (is_dec_s && !is_inc_s)    cnt_s_nxt[i] = cnt_s[i] - CNT_ONE;
      if (is_dec_v && (cnt_v[i] == '0))  err_nxt = 1'b1;
      else if (is_inc_v && !is_dec_v)    cnt_v_nxt[i] = cnt_v[i] + CNT_ONE;
      else if (is_dec_v && !is_inc_v)    cnt_v_nxt[i] = cnt_v[i] - CNT_ONE;
    end
    for (int i = 0; i < NREG; i++) begin
      pending_s_nxt[i] = (cnt_s_nxt[i] != '0);
      pending_v_nxt[i] = (cnt_v_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_s[i] <= '0;
        cnt_v[i] <= '0;
      end
      pending_s <= '0;
      pending_v <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_s[i] <= cnt_s_nxt[i];
        cnt_v[i] <= cnt_v_nxt[i];
      end
      pending_s <= pending_s_nxt;
      pending_v <= pending_v_nxt;
      busy      <= (|pending_s_nxt) || (|pending_v_nxt);
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// tb/tb_reg_write_scoreboard.sv - scoreboard bench for reg_write_scoreboard
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_reg_write_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [3:0]  issue_rs1;
  logic        issue_rs1_vec;
  logic        issue_rs1_used;
  logic [3:0]  issue_rs2;
  logic        issue_rs2_vec;
  logic        issue_rs2_used;
  logic [3:0]  issue_rd;
  logic        issue_regWrite;
  logic        issue_regWriteV;
  logic        wb_regWrite;
  logic        wb_regWriteV;
  logic [3:0]  wb_rd;
  logic        stall;
  logic [15:0] pending_s;
  logic [15:0] pending_v;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        stall;
    logic [15:0] ps;
    logic [15:0] pv;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  reg_write_scoreboard #(.NREG(16), .REG_W(4), .CNT_W(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid     (issue_valid),
    .issue_rs1       (issue_rs1),
    .issue_rs1_vec   (issue_rs1_vec),
    .issue_rs1_used  (issue_rs1_used),
    .issue_rs2       (issue_rs2),
    .issue_rs2_vec   (issue_rs2_vec),
    .issue_rs2_used  (issue_rs2_used),
    .issue_rd        (issue_rd),
    .issue_regWrite  (issue_regWrite),
    .issue_regWriteV (issue_regWriteV),
    .wb_regWrite     (wb_regWrite),
    .wb_regWriteV    (wb_regWriteV),
    .wb_rd           (wb_rd),
    .stall           (stall),
    .pending_s       (pending_s),
    .pending_v       (pending_v),
    .busy            (busy),
    .err             (err)
  );

  task automatic cmp(input string n, input string f, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s.%s: got %h expected %h", n, f, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.name, "stall",     {15'd0, stall}, {15'd0, e.stall});
      cmp(e.name, "pending_s", pending_s,      e.ps);
      cmp(e.name, "pending_v", pending_v,      e.pv);
      cmp(e.name, "busy",      {15'd0, busy},  {15'd0, e.busy});
      cmp(e.name, "err",       {15'd0, err},   {15'd0, e.err});
    end
  end

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs1_vec = 0; issue_rs1_used = 0;
    issue_rs2 = 0; issue_rs2_vec = 0; issue_rs2_used = 0; issue_rd = 0;
    issue_regWrite = 0; issue_regWriteV = 0;
    wb_regWrite = 0; wb_regWriteV = 0; wb_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic iss(input logic [3:0] rd, input logic w, input logic wv);
    issue_valid = 1; issue_rd = rd; issue_regWrite = w; issue_regWriteV = wv;
  endtask

  task automatic rd1(input logic [3:0] r, input logic vec, input logic used);
    issue_valid = 1; issue_rs1 = r; issue_rs1_vec = vec; issue_rs1_used = used;
  endtask

  task automatic wb(input logic [3:0] rd, input logic w, input logic wv);
    wb_rd = rd; wb_regWrite = w; wb_regWriteV = wv;
  endtask

  task automatic chk(input string n, input logic s, input logic [15:0] ps,
                     input logic [15:0] pv, input logic b, input logic e);
    exp_t x;
    x.name = n; x.stall = s; x.ps = ps; x.pv = pv; x.busy = b; x.err = e;
    exp_q.push_back(x);
  endtask

  initial begin
    rst = 1;
    idle();
    tick(); rd1(3, 0, 1); chk("reset", 0, 16'h0, 16'h0, 0, 0);
    tick(); rst = 0; iss(3, 1, 0); chk("t1_accept", 0, 16'h0, 16'h0, 0, 0);
    tick(); rd1(3, 0, 1); chk("t1_hazard", 1, 16'h0008, 16'h0, 1, 0);
    tick(); rd1(3, 0, 1); wb(3, 1, 0); chk("t2_same_cycle", 1, 16'h0008, 16'h0, 1, 0);
    tick(); rd1(3, 0, 1); chk("t2_cleared", 0, 16'h0, 16'h0, 0, 0);

    tick(); iss(5, 0, 1); chk("t3_w1", 0, 16'h0, 16'h0, 0, 0);
    tick(); iss(5, 0, 1); chk("t3_w2", 0, 16'h0, 16'h0020, 1, 0);
    tick(); iss(5, 0, 1); chk("t3_w3", 0, 16'h0, 16'h0020, 1, 0);
    tick(); iss(5, 0, 1); chk("t3_full", 1, 16'h0, 16'h0020, 1, 0);
    tick(); rd1(5, 0, 1); chk("t3_scalar_rd", 0, 16'h0, 16'h0020, 1, 0);
    tick(); rd1(5, 1, 1); chk("t3_vec_rs1", 1, 16'h0, 16'h0020, 1, 0);
    tick(); issue_valid = 1; issue_rs2 = 5; issue_rs2_vec = 1; issue_rs2_used = 1;
    chk("t3_vec_rs2", 1, 16'h0, 16'h0020, 1, 0);
    tick(); rd1(5, 1, 0); chk("t3_unused", 0, 16'h0, 16'h0020, 1, 0);

    tick(); iss(7, 1, 0); chk("t4_first", 0, 16'h0, 16'h0020, 1, 0);
    tick(); iss(7, 1, 0); wb(7, 1, 0); chk("t4_incdec", 0, 16'h0080, 16'h0020, 1, 0);
    tick(); chk("t4_hold", 0, 16'h0080, 16'h0020, 1, 0);
    tick(); wb(7, 1, 0); chk("t4_wb", 0, 16'h0080, 16'h0020, 1, 0);
    tick(); wb(5, 0, 1); chk("drain_v1", 0, 16'h0, 16'h0020, 1, 0);
    tick(); wb(5, 0, 1); chk("drain_v2", 0, 16'h0, 16'h0020, 1, 0);
    tick(); wb(5, 0, 1); chk("drain_v3", 0, 16'h0, 16'h0020, 1, 0);
    tick(); chk("drained", 0, 16'h0, 16'h0, 0, 0);

    tick(); iss(0, 1, 0); wb(0, 1, 0); chk("t6_rd0_issue", 0, 16'h0, 16'h0, 0, 0);
    tick(); chk("t6_rd0_after", 0, 16'h0, 16'h0, 0, 0);

    tick(); wb(9, 1, 0); chk("t5_uf_cycle", 0, 16'h0, 16'h0, 0, 0);
    tick(); chk("t5_err", 0, 16'h0, 16'h0, 0, 1);
    tick(); chk("t5_sticky", 0, 16'h0, 16'h0, 0, 1);
    tick(); rst = 1; chk("t5_pre_rst", 0, 16'h0, 16'h0, 0, 1);
    tick(); rst = 0; chk("t5_rst_clear", 0, 16'h0, 16'h0, 0, 0);

    tick(); iss(4, 1, 1); chk("t6_both_cycle", 0, 16'h0, 16'h0, 0, 0);
    tick(); chk("t6_both_err", 0, 16'h0, 16'h0, 0, 1);

    tick(); rst = 1; chk("mid_pre", 0, 16'h0, 16'h0, 0, 1);
    tick(); rst = 0; iss(2, 1, 0); chk("mid_a", 0, 16'h0, 16'h0, 0, 0);
    tick(); iss(2, 1, 0); chk("mid_b", 0, 16'h0004, 16'h0, 1, 0);
    tick(); rst = 1; rd1(2, 0, 1); chk("stall_in_rst", 0, 16'h0004, 16'h0, 1, 0);
    tick(); rst = 0; chk("mid_flushed", 0, 16'h0, 16'h0, 0, 0);
    tick(); wb(2, 1, 0); chk("post_rst_wb", 0, 16'h0, 16'h0, 0, 0);
    tick(); chk("post_rst_uf", 0, 16'h0, 16'h0, 0, 1);

    tick(); rst = 1;
    tick(); rst = 0; iss(6, 1, 0); chk("wbb_issue", 0, 16'h0, 16'h0, 0, 0);
    tick(); wb(6, 1, 1); chk("wbb_cycle", 0, 16'h0040, 16'h0, 1, 0);
    tick(); chk("wbb_err", 0, 16'h0040, 16'h0, 1, 1);

    tick();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
